// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: instruction decode, register file with optional
// write-to-read bypass, and the D->E pipeline register with stall/flush.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            valid_d,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            we3,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd3,
    output logic            valid_e,
    output logic            illegal_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic            alu_src_e,
    output logic [1:0]      result_src_e,
    output logic [2:0]      alu_control_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e
);

    localparam bit RV32E = (NREG == 16);
    localparam int AW    = RV32E ? 4 : 5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREG];
    logic            rf_we;

    assign rf_we = we3 && (a3 != 5'd0) && !(RV32E && a3[4]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[a3[AW-1:0]] <= wd3;
        end
    end

    // Indices outside the RV32E file read as zero; such instructions are flagged illegal.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != 5'd0 && !(RV32E && idx[4])) begin
            if (BYPASS != 0 && we3 && idx == a3) begin
                v = wd3;
            end else begin
                v = regs_q[idx[AW-1:0]];
            end
        end
        return v;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] op;
    logic [2:0] funct3;
    logic [4:0] rs1_f, rs2_f, rd_f;

    assign op     = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign rs1_f  = instr_d[19:15];
    assign rs2_f  = instr_d[24:20];
    assign rd_f   = instr_d[11:7];

    logic [2:0] alu_fn;
    logic       alu_fn_bad;

    always_comb begin
        alu_fn     = ALU_ADD;
        alu_fn_bad = 1'b0;
        unique case (funct3)
            3'b000:  alu_fn = (instr_d[30] && op[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn_bad = 1'b1;
        endcase
    end

    logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]      result_src_d;
    logic [2:0]      alu_control_d;
    logic            illegal_d, bad_instr;
    logic            use_rs1, use_rs2, use_rd, zero_rd1;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext_d, rd1_d, rd2_d;

    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        result_src_d  = 2'b00;
        alu_control_d = ALU_ADD;
        bad_instr     = 1'b0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        use_rd        = 1'b0;
        zero_rd1      = 1'b0;
        imm32         = 32'h0;
        case (op)
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
                imm32        = {{20{instr_d[31]}}, instr_d[31:20]};
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm32       = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_R: begin
                reg_write_d   = 1'b1;
                alu_control_d = alu_fn;
                bad_instr     = alu_fn_bad;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                use_rd        = 1'b1;
            end
            OP_I: begin
                reg_write_d   = 1'b1;
                alu_src_d     = 1'b1;
                alu_control_d = alu_fn;
                bad_instr     = alu_fn_bad;
                imm32         = {{20{instr_d[31]}}, instr_d[31:20]};
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
            end
            OP_BEQ: begin
                branch_d      = 1'b1;
                alu_control_d = ALU_SUB;
                imm32         = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                 instr_d[30:25], instr_d[11:8], 1'b0};
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                jump_d       = 1'b1;
                result_src_d = 2'b10;
                imm32        = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                                instr_d[20], instr_d[30:21], 1'b0};
                use_rd       = 1'b1;
            end
            OP_LUI: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm32       = {instr_d[31:12], 12'h000};
                use_rd      = 1'b1;
                zero_rd1    = 1'b1;
            end
            default: bad_instr = 1'b1;
        endcase

        if (RV32E && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]))) begin
            bad_instr = 1'b1;
        end

        // Bubbles and illegal instructions must never cause side effects downstream.
        if (bad_instr || !valid_d) begin
            reg_write_d   = 1'b0;
            mem_write_d   = 1'b0;
            jump_d        = 1'b0;
            branch_d      = 1'b0;
            alu_src_d     = 1'b0;
            result_src_d  = 2'b00;
            alu_control_d = ALU_ADD;
        end
        illegal_d = bad_instr && valid_d;

        imm_ext_d = sext32(imm32);
        rd1_d     = zero_rd1 ? '0 : rf_read(rs1_f);
        rd2_d     = rf_read(rs2_f);
    end

    // ------------------------------------------------------------------
    // D->E pipeline register
    // ------------------------------------------------------------------
    logic            valid_q, illegal_q, reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
    logic [1:0]      result_src_q;
    logic [2:0]      alu_control_q;
    logic [XLEN-1:0] rd1_q, rd2_q, imm_ext_q, pc_q, pc_plus4_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;

    // Flush clears only validity and controls; data fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            result_src_q  <= 2'b00;
            alu_control_q <= 3'b000;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_ext_q     <= '0;
            pc_q          <= '0;
            pc_plus4_q    <= '0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
        end else if (flush_e) begin
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            result_src_q  <= 2'b00;
            alu_control_q <= 3'b000;
        end else if (!stall_e) begin
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
            reg_write_q   <= reg_write_d;
            mem_write_q   <= mem_write_d;
            jump_q        <= jump_d;
            branch_q      <= branch_d;
            alu_src_q     <= alu_src_d;
            result_src_q  <= result_src_d;
            alu_control_q <= alu_control_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_ext_q     <= imm_ext_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            rs1_q         <= rs1_f;
            rs2_q         <= rs2_f;
            rd_q          <= rd_f;
        end
    end

    assign valid_e       = valid_q;
    assign illegal_e     = illegal_q;
    assign reg_write_e   = reg_write_q;
    assign mem_write_e   = mem_write_q;
    assign jump_e        = jump_q;
    assign branch_e      = branch_q;
    assign alu_src_e     = alu_src_q;
    assign result_src_e  = result_src_q;
    assign alu_control_e = alu_control_q;
    assign rd1_e         = rd1_q;
    assign rd2_e         = rd2_q;
    assign imm_ext_e     = imm_ext_q;
    assign pc_e          = pc_q;
    assign pc_plus4_e    = pc_plus4_q;
    assign rs1_e         = rs1_q;
    assign rs2_e         = rs2_q;
    assign rd_e          = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32I/bypass instance and an RV32E/no-bypass
// instance share one stimulus stream; table vectors plus hand sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, valid_d, stall_e, flush_e, we3;
    logic [31:0] instr_d, pc_d, pc_plus4_d, wd3;
    logic [4:0]  a3;

    always #5 clk = ~clk;

    logic        a_valid, a_illegal, a_reg_write, a_mem_write, a_jump, a_branch, a_alu_src;
    logic [1:0]  a_result_src;
    logic [2:0]  a_alu_control;
    logic [31:0] a_rd1, a_rd2, a_imm, a_pc, a_pc4;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic        b_valid, b_illegal, b_reg_write, b_mem_write, b_jump, b_branch, b_alu_src;
    logic [1:0]  b_result_src;
    logic [2:0]  b_alu_control;
    logic [31:0] b_rd1, b_rd2, b_imm, b_pc, b_pc4;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [9:0]  a_ctrl, b_ctrl;

    assign a_ctrl = {a_reg_write, a_mem_write, a_jump, a_branch, a_alu_src, a_result_src, a_alu_control};
    assign b_ctrl = {b_reg_write, b_mem_write, b_jump, b_branch, b_alu_src, b_result_src, b_alu_control};

    decode_stage #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e), .we3(we3), .a3(a3), .wd3(wd3),
        .valid_e(a_valid), .illegal_e(a_illegal), .reg_write_e(a_reg_write),
        .mem_write_e(a_mem_write), .jump_e(a_jump), .branch_e(a_branch), .alu_src_e(a_alu_src),
        .result_src_e(a_result_src), .alu_control_e(a_alu_control), .rd1_e(a_rd1), .rd2_e(a_rd2),
        .imm_ext_e(a_imm), .pc_e(a_pc), .pc_plus4_e(a_pc4), .rs1_e(a_rs1), .rs2_e(a_rs2), .rd_e(a_rd)
    );

    decode_stage #(.XLEN(32), .NREG(16), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e), .we3(we3), .a3(a3), .wd3(wd3),
        .valid_e(b_valid), .illegal_e(b_illegal), .reg_write_e(b_reg_write),
        .mem_write_e(b_mem_write), .jump_e(b_jump), .branch_e(b_branch), .alu_src_e(b_alu_src),
        .result_src_e(b_result_src), .alu_control_e(b_alu_control), .rd1_e(b_rd1), .rd2_e(b_rd2),
        .imm_ext_e(b_imm), .pc_e(b_pc), .pc_plus4_e(b_pc4), .rs1_e(b_rs1), .rs2_e(b_rs2), .rd_e(b_rd)
    );

    // Control pack order: reg_write, mem_write, jump, branch, alu_src, result_src[1:0], alu_control[2:0]
    localparam logic [9:0] C_NONE = 10'b0;
    localparam logic [9:0] C_LW   = {5'b10001, 2'b01, 3'b000};
    localparam logic [9:0] C_SW   = {5'b01001, 2'b00, 3'b000};
    localparam logic [9:0] C_BEQ  = {5'b00010, 2'b00, 3'b001};
    localparam logic [9:0] C_JAL  = {5'b10100, 2'b10, 3'b000};
    localparam logic [9:0] C_LUI  = {5'b10001, 2'b00, 3'b000};

    function automatic logic [9:0] c_r(input logic [2:0] alu);
        return {5'b10000, 2'b00, alu};
    endfunction
    function automatic logic [9:0] c_i(input logic [2:0] alu);
        return {5'b10001, 2'b00, alu};
    endfunction

    typedef struct {
        logic        rst, valid, stall, flush, we;
        logic [4:0]  a3;
        logic [31:0] wd3, instr;
        logic        exp_valid, exp_ill;
        logic [9:0]  exp_ctrl;
        logic        chk_rd;
        logic [31:0] exp_rd1, exp_rd2;
        logic [4:0]  exp_rd;
        logic        chk_imm;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, v, s, f, w, input logic [4:0] wa, input logic [31:0] wd, ins,
                       input logic ev, ei, input logic [9:0] ec, input logic crd,
                       input logic [31:0] e1, e2, input logic [4:0] erd,
                       input logic cim, input logic [31:0] eim);
        vec_t t;
        t.rst = r; t.valid = v; t.stall = s; t.flush = f; t.we = w; t.a3 = wa; t.wd3 = wd;
        t.instr = ins; t.exp_valid = ev; t.exp_ill = ei; t.exp_ctrl = ec; t.chk_rd = crd;
        t.exp_rd1 = e1; t.exp_rd2 = e2; t.exp_rd = erd; t.chk_imm = cim; t.exp_imm = eim;
        tv.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, v, s, f, w, input logic [4:0] wa,
                         input logic [31:0] wd, ins, pc);
        rst = r; valid_d = v; stall_e = s; flush_e = f; we3 = w; a3 = wa; wd3 = wd;
        instr_d = ins; pc_d = pc; pc_plus4_d = pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

        //  rst  v  s  f  we a3     wd3           instr         ev ei ctrl       crd rd1           rd2           rd    cim imm
        add(1, 1, 0, 0, 1, 5'd5,  32'hDEADBEEF, 32'h005283B3, 0, 0, C_NONE,    1, 32'h0,        32'h0,        5'd0,  1, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h005283B3, 1, 0, c_r(3'd0), 1, 32'h0,        32'h0,        5'd7,  0, 32'h0);
        add(0, 0, 0, 0, 1, 5'd5,  32'h12345678, 32'h005283B3, 0, 0, C_NONE,    1, 32'h12345678, 32'h12345678, 5'd7,  0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h005283B3, 1, 0, c_r(3'd0), 1, 32'h12345678, 32'h12345678, 5'd7,  0, 32'h0);
        add(0, 1, 0, 0, 1, 5'd6,  32'hCAFEBABE, 32'hFE612E23, 1, 0, C_SW,      1, 32'h0,        32'hCAFEBABE, 5'd28, 1, 32'hFFFFFFFC);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'hFE000EE3, 1, 0, C_BEQ,     1, 32'h0,        32'h0,        5'd29, 1, 32'hFFFFFFFC);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0080006F, 1, 0, C_JAL,     1, 32'h0,        32'h0,        5'd0,  1, 32'h00000008);
        add(0, 1, 0, 0, 1, 5'd8,  32'h00000055, 32'h123454B7, 1, 0, C_LUI,     1, 32'h0,        32'h0,        5'd9,  1, 32'h12345000);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'hFFF2A513, 1, 0, c_i(3'd5), 1, 32'h12345678, 32'h0,        5'd10, 1, 32'hFFFFFFFF);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h407285B3, 1, 0, c_r(3'd1), 1, 32'h12345678, 32'h0,        5'd11, 0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0052F633, 1, 0, c_r(3'd2), 1, 32'h12345678, 32'h12345678, 5'd12, 0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0052E6B3, 1, 0, c_r(3'd3), 1, 32'h12345678, 32'h12345678, 5'd13, 0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h005296B3, 1, 1, C_NONE,    1, 32'h12345678, 32'h12345678, 5'd13, 0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0000007F, 1, 1, C_NONE,    1, 32'h0,        32'h0,        5'd0,  0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0082A703, 1, 0, C_LW,      1, 32'h12345678, 32'h00000055, 5'd14, 1, 32'h00000008);
        add(0, 1, 0, 0, 1, 5'd0,  32'hFFFFFFFF, 32'h000003B3, 1, 0, c_r(3'd0), 1, 32'h0,        32'h0,        5'd7,  0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h000003B3, 1, 0, c_r(3'd0), 1, 32'h0,        32'h0,        5'd7,  0, 32'h0);
        add(0, 1, 0, 0, 0, 5'd0,  32'h0,        32'hC0028093, 1, 0, c_i(3'd0), 1, 32'h12345678, 32'h0,        5'd1,  1, 32'hFFFFFC00);
        add(0, 0, 0, 0, 0, 5'd0,  32'h0,        32'h0000007F, 0, 0, C_NONE,    0, 32'h0,        32'h0,        5'd0,  0, 32'h0);
        add(0, 1, 0, 1, 0, 5'd0,  32'h0,        32'h005283B3, 0, 0, C_NONE,    0, 32'h0,        32'h0,        5'd0,  0, 32'h0);

        foreach (tv[i]) begin
            pc = 32'h1000 + 32'(i) * 32'd4;
            drive(tv[i].rst, tv[i].valid, tv[i].stall, tv[i].flush, tv[i].we,
                  tv[i].a3, tv[i].wd3, tv[i].instr, pc);
            chk($sformatf("v%0d valid_e", i), 32'(a_valid), 32'(tv[i].exp_valid));
            chk($sformatf("v%0d illegal_e", i), 32'(a_illegal), 32'(tv[i].exp_ill));
            chk($sformatf("v%0d ctrl", i), 32'(a_ctrl), 32'(tv[i].exp_ctrl));
            if (tv[i].chk_rd) begin
                chk($sformatf("v%0d rd1_e", i), a_rd1, tv[i].exp_rd1);
                chk($sformatf("v%0d rd2_e", i), a_rd2, tv[i].exp_rd2);
                chk($sformatf("v%0d rd_e", i), 32'(a_rd), 32'(tv[i].exp_rd));
                chk($sformatf("v%0d pc_e", i), a_pc, tv[i].rst ? 32'h0 : pc);
            end
            if (tv[i].chk_imm) begin
                chk($sformatf("v%0d imm_ext_e", i), a_imm, tv[i].exp_imm);
            end
        end

        // Stall holds E-side state while register-file writes continue.
        drive(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0082A703, 32'h2000);
        chk("stall_pre ctrl", 32'(a_ctrl), 32'(C_LW));
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 0, 1, 5'd20, 32'hA5A5A5A5, 32'hFE000EE3, 32'h3000 + 32'(k));
            chk($sformatf("stall%0d valid_e", k), 32'(a_valid), 32'd1);
            chk($sformatf("stall%0d ctrl", k), 32'(a_ctrl), 32'(C_LW));
            chk($sformatf("stall%0d rd_e", k), 32'(a_rd), 32'd14);
            chk($sformatf("stall%0d imm", k), a_imm, 32'h8);
            chk($sformatf("stall%0d rd1_e", k), a_rd1, 32'h12345678);
            chk($sformatf("stall%0d pc_e", k), a_pc, 32'h2000);
        end
        drive(0, 1, 1, 1, 0, 5'd0, 32'h0, 32'h005283B3, 32'h4000);
        chk("stallflush valid_e", 32'(a_valid), 32'd0);
        chk("stallflush illegal_e", 32'(a_illegal), 32'd0);
        chk("stallflush ctrl", 32'(a_ctrl), 32'(C_NONE));
        drive(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h000A0AB3, 32'h4004);
        chk("stallwrite rd1_e", a_rd1, 32'hA5A5A5A5);
        chk("rv32e x20 illegal_e", 32'(b_illegal), 32'd1);
        chk("rv32e x20 ctrl", 32'(b_ctrl), 32'(C_NONE));

        // RV32E index range and no-bypass behaviour.
        drive(0, 1, 0, 0, 1, 5'd17, 32'h00000077, 32'h001088B3, 32'h5000);
        chk("x17 rv32i illegal_e", 32'(a_illegal), 32'd0);
        chk("x17 rv32i ctrl", 32'(a_ctrl), 32'(c_r(3'd0)));
        chk("x17 rv32e illegal_e", 32'(b_illegal), 32'd1);
        chk("x17 rv32e ctrl", 32'(b_ctrl), 32'(C_NONE));
        drive(0, 1, 0, 0, 1, 5'd6, 32'h00000011, 32'hFE612E23, 32'h5004);
        chk("bypass rd2_e", a_rd2, 32'h00000011);
        chk("nobypass rd2_e", b_rd2, 32'hCAFEBABE);
        chk("nobypass mem_write", 32'(b_mem_write), 32'd1);
        drive(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h00608133, 32'h5008);
        chk("rv32e x1 rd1_e", b_rd1, 32'h0);
        chk("rv32e x6 rd2_e", b_rd2, 32'h00000011);
        chk("rv32i x6 rd2_e", a_rd2, 32'h00000011);

        // Reset during stall+flush clears everything, including the register file.
        drive(1, 1, 1, 1, 1, 5'd5, 32'h00000009, 32'h005283B3, 32'h6000);
        chk("rst valid_e", 32'(a_valid), 32'd0);
        chk("rst ctrl", 32'(a_ctrl), 32'(C_NONE));
        chk("rst rd_e", 32'(a_rd), 32'd0);
        chk("rst rs1_e", 32'(a_rs1), 32'd0);
        chk("rst rd1_e", a_rd1, 32'h0);
        chk("rst pc_plus4_e", a_pc4, 32'h0);
        drive(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h005283B3, 32'h6004);
        chk("postrst rd1_e", a_rd1, 32'h0);
        chk("postrst b rd2_e", b_rd2, 32'h0);
        chk("postrst rs1_e", 32'(a_rs1), 32'd5);
        chk("postrst pc_plus4_e", a_pc4, 32'h6008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
